// File: rtl/dpram_rd_pkg.sv
// Shared types and defaults for the dual-port RAM burst read engine.
// Holds the FSM state encoding, default widths and the skid FIFO depth.
// Imported by the interface, the skid FIFO and the engine top.
package dpram_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_AW     = 9;
   localparam int DEF_DW     = 16;
   localparam int DEF_LW     = 9;
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/dpram_rd_engine_if.sv
// Command and output-stream bundle of the burst read engine.
// master: scheduler/egress side (offers commands, accepts words).
// slave : the engine (accepts commands, presents words).
interface dpram_rd_engine_if #(
   parameter int AW = 9,
   parameter int DW = 16,
   parameter int LW = 9
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, out_ready,
      input  cmd_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, out_ready,
      output cmd_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding read data plus its last flag.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the engine's credit rule keeps it from overflowing.
module rd_skid_fifo
   import dpram_rd_pkg::*;
#(
   parameter int W = DEF_DW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] head_dat
);
   logic [W-1:0] mem [FIFO_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;

   // Storage, pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/dpram_rd_engine.sv
// Burst read engine: turns (addr, len) commands into sequential RAM reads and a last-flagged stream.
// Latency: accept -> ram_re next cycle -> out_valid one cycle later; len words finish len+2 cycles after accept.
// Backpressure: reads issue only while FIFO occupancy + in-flight read < 2. Optional DPRAM_RD_STAT_EN adds stats.
module dpram_rd_engine
   import dpram_rd_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter int LW = DEF_LW
) (
   input  logic          clk,
   input  logic          rst_n,
   dpram_rd_engine_if.slave bus,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_dout,
   output logic          done
`ifdef DPRAM_RD_STAT_EN
   ,
   output logic [31:0]   stat_words,
   output logic [15:0]   stat_bursts
`endif
);
   state_t        state;
   logic [AW-1:0] addr_q;
   logic [LW-1:0] rem_q;
   logic          cmd_ready_q;
   logic          done_q;
   logic          inflight_q;
   logic          inflight_last_q;

   logic [1:0]    fifo_cnt;
   logic [DW:0]   head_dat;
   logic          head_vld;
   logic          push;
   logic          pop;
   logic          issue;
   logic          accept;
   logic          xfer;

   assign accept   = bus.cmd_valid & cmd_ready_q;
   assign xfer     = bus.out_valid & bus.out_ready;
   assign head_vld = (fifo_cnt != 2'd0);

   // A read may go out only if its word is guaranteed a FIFO slot whatever out_ready does
   assign issue = (state == READ) && (rem_q != '0) &&
                  ((fifo_cnt + {1'b0, inflight_q}) < 2'd2);

   assign ram_re        = issue;
   assign ram_raddr     = addr_q;
   assign bus.cmd_ready = cmd_ready_q;
   assign done          = done_q;

   // Output head: FIFO word first; with an empty FIFO the arriving RAM word passes straight through.
   // A bypassed word that is not taken is pushed, so the next cycle shows the same word from the FIFO.
   always_comb begin
      bus.out_valid = head_vld | inflight_q;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      if (head_vld) begin
         bus.out_data = head_dat[DW-1:0];
         bus.out_last = head_dat[DW];
      end else if (inflight_q) begin
         bus.out_data = ram_dout;
         bus.out_last = inflight_last_q;
      end
      pop  = head_vld & bus.out_ready;
      push = inflight_q & (head_vld | ~bus.out_ready);
   end

   rd_skid_fifo #(.W(DW + 1)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat ({inflight_last_q, ram_dout}),
      .pop      (pop),
      .count    (fifo_cnt),
      .head_dat (head_dat)
   );

   // Command FSM with address/length counters, in-flight tracking and registered ready/done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         cmd_ready_q     <= 1'b0;
         done_q          <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         done_q          <= 1'b0;
         inflight_q      <= issue;
         inflight_last_q <= issue && (rem_q == LW'(1));
         case (state)
            IDLE: begin
               // ready drops for the accept cycle and the done cycle that follows
               cmd_ready_q <= 1'b1;
               if (accept) begin
                  addr_q      <= bus.cmd_addr;
                  rem_q       <= bus.cmd_len;
                  cmd_ready_q <= 1'b0;
                  if (bus.cmd_len == '0) done_q <= 1'b1;
                  else                   state  <= READ;
               end
            end
            READ: begin
               cmd_ready_q <= 1'b0;
               if (issue) begin
                  addr_q <= addr_q + AW'(1);
                  rem_q  <= rem_q - LW'(1);
                  if (rem_q == LW'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               cmd_ready_q <= 1'b0;
               if (xfer && bus.out_last) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               cmd_ready_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

`ifdef DPRAM_RD_STAT_EN
   // Delivered-word counter (saturating) and done-pulse counter (wrapping)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words  <= '0;
         stat_bursts <= '0;
      end else begin
         if (xfer && (stat_words != 32'hFFFF_FFFF)) stat_words <= stat_words + 32'd1;
         stat_bursts <= stat_bursts + {15'd0, done_q};
      end
   end
`endif
endmodule

// File: tb/tb_dpram_rd_engine.sv
// Scoreboard bench for dpram_rd_engine: stimulus pushes expected words/addresses, a monitor pops and compares.
// The RAM is modelled as an array with one-cycle read latency.
// out_ready is driven constant, random, or held low for stall windows.
module tb_dpram_rd_engine;
   localparam int AW = 9;
   localparam int DW = 16;
   localparam int LW = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_dout = '0;
   logic          done;
`ifdef DPRAM_RD_STAT_EN
   logic [31:0]   stat_words;
   logic [15:0]   stat_bursts;
`endif

   dpram_rd_engine_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

   dpram_rd_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_re    (ram_re),
      .ram_raddr (ram_raddr),
      .ram_dout  (ram_dout),
      .done      (done)
`ifdef DPRAM_RD_STAT_EN
      ,
      .stat_words  (stat_words),
      .stat_bursts (stat_bursts)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram_mem [1 << AW];
   always @(posedge clk) if (ram_re) ram_dout <= ram_mem[ram_raddr];

   logic [DW:0]   exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  xfer_cnt = 0;
   int  done_cnt = 0;
   int  words_since_rst = 0;
   int  bursts_since_rst = 0;
   int  max_cnt = 0;
   int  stall_cnt = 0;
   bit  rand_ready = 1'b0;
   bit  done_exp = 1'b0;
   bit  stall_prev = 1'b0;
   logic [DW:0] stall_word = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event with nothing expected", name);
   endtask

   // out_ready driver
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
         end else if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         else bus.out_ready = 1'b1;
      end
   end

   // Monitor: compares addresses, words, stall stability and done timing against the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         done_exp = 1'b0;
         stall_prev = 1'b0;
         words_since_rst = 0;
         bursts_since_rst = 0;
      end else begin
         if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
         if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_word", 32'({bus.out_last, bus.out_data}), 32'(stall_word));
         end
         if (ram_re) begin
            if (exp_addr_q.size() == 0) fail_now("spurious_ram_re");
            else chk("raddr", 32'(ram_raddr), 32'(exp_addr_q.pop_front()));
         end
         if (bus.out_valid && bus.out_ready) begin
            xfer_cnt++;
            words_since_rst++;
            if (exp_q.size() == 0) fail_now("spurious_word");
            else chk("word", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
         end
         if (done || done_exp) chk("done_timing", 32'(done), 32'(done_exp));
         if (done) begin
            done_cnt++;
            bursts_since_rst++;
         end
         done_exp = (bus.out_valid && bus.out_ready && bus.out_last) ||
                    (bus.cmd_valid && bus.cmd_ready && bus.cmd_len == '0);
         stall_prev = bus.out_valid && !bus.out_ready;
         stall_word = {bus.out_last, bus.out_data};
      end
   end

   // Model the burst, offer it, and return right after the accepting edge
   task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
      int n;
      logic [AW-1:0] wa;
      for (int i = 0; i < int'(l); i++) begin
         wa = a + AW'(i);
         exp_addr_q.push_back(wa);
         exp_q.push_back({(i == int'(l) - 1), ram_mem[wa]});
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.cmd_ready) chk("cmd_accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      chk("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'd0);
   endtask

   task automatic wait_done(input logic [LW-1:0] l, input bit chk_lat);
      int n = 0;
      while (!done && n < 3000) begin @(posedge clk); #1; n++; end
      if (!done) chk("done_timeout", 32'(n), 32'd0);
      else if (chk_lat) chk("done_latency", 32'(n), (l == '0) ? 32'd0 : 32'(l) + 32'd1);
   endtask

   initial begin
      int n;
      int d0;
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'($urandom);
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_ram_re", 32'(ram_re), 32'd0);
      chk("rst_raddr", 32'(ram_raddr), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("post_rst_ram_re", 32'(ram_re), 32'd0);

      // Straight burst at full throughput, then an address wrap
      issue_cmd(9'h010, 9'd5);
      wait_done(9'd5, 1'b1);
      issue_cmd(9'h1FE, 9'd4);
      wait_done(9'd4, 1'b1);

      // len=8 under random out_ready with a 20-cycle stall
      rand_ready = 1'b1;
      fork
         begin issue_cmd(9'h0A0, 9'd8); wait_done(9'd8, 1'b0); end
         begin repeat (3) @(posedge clk); #2; stall_cnt = 20; end
      join
      chk("fifo_max_occupancy", 32'(max_cnt), 32'd2);
      rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Empty burst, then back-to-back len=3 offered in the done cycle
      d0 = done_cnt;
      issue_cmd(9'h123, 9'd0);
      wait_done(9'd0, 1'b1);
      chk("cmd_ready_in_done_cycle", 32'(bus.cmd_ready), 32'd0);
      issue_cmd(9'h055, 9'd3);
      wait_done(9'd3, 1'b1);
      @(posedge clk); #1;
      chk("done_pulses_two_cmds", 32'(done_cnt - d0), 32'd2);

      // Randomized commands under random backpressure
      rand_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         issue_cmd(AW'($urandom), LW'($urandom_range(0, 12)));
         wait_done(bus.cmd_len, 1'b0);
      end
      rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset while word 3 of a len=10 burst is on the output
      d0 = xfer_cnt;
      issue_cmd(9'h040, 9'd10);
      n = 0;
      while (xfer_cnt < d0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
      chk("mid_word3_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
      chk("mid_rst_ram_re", 32'(ram_re), 32'd0);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_done_after_mid_rst", 32'(done_cnt), 32'(d0));
      issue_cmd(9'h0F0, 9'd4);
      wait_done(9'd4, 1'b1);
      @(posedge clk); #1;
`ifdef DPRAM_RD_STAT_EN
      chk("stat_words", stat_words, 32'(words_since_rst));
      chk("stat_bursts", 32'(stat_bursts), 32'(bursts_since_rst));
`endif
      chk("exp_words_left", 32'(exp_q.size()), 32'd0);
      chk("exp_addrs_left", 32'(exp_addr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
